// File: rtl/uart_rx_buffer_pkg.sv
// Shared types and constants for the uart_rx receive FIFO.
package uart_rx_buffer_pkg;

    localparam int unsigned RxDataWidth = 8;

    // One stored frame: parity flag alongside the received byte.
    typedef struct packed {
        logic                   parity_err;
        logic [RxDataWidth-1:0] data;
    } uart_rx_entry_t;

endpackage : uart_rx_buffer_pkg

// File: rtl/uart_rx_buffer_timer.sv
// Idle-timeout tracker for uart_rx_buffer. The counter runs while data is held
// and nothing moves, then saturates. timeout_o stays up until the next activity.
// Only instantiated when UART_RX_BUF_TIMEOUT_EN is defined.
module uart_rx_buffer_timer #(
    parameter int unsigned TimeoutCycles = 512
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic empty_i,
    input  logic activity_i,
    output logic timeout_o
);

    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic            idle;

    assign idle = !empty_i && !activity_i;

    // Next-state for the saturating idle counter and the timeout flag.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (!idle) begin
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else if (cnt_q == CntMax) begin
            timeout_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule : uart_rx_buffer_timer

// File: rtl/uart_rx_buffer.sv
// Receive-side FWFT byte FIFO downstream of uart_rx. Stores {parity_err, data}
// per frame, reports level/full/empty, sticky overflow and (when the
// UART_RX_BUF_TIMEOUT_EN macro is defined) an idle timeout.
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int unsigned Depth         = 16,
    parameter int unsigned TimeoutCycles = 512
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic [RxDataWidth-1:0]    wr_data_i,
    input  logic                      wr_parity_err_i,
    input  logic                      wr_valid_i,
    output logic [RxDataWidth-1:0]    rd_data_o,
    output logic                      rd_parity_err_o,
    output logic                      rd_valid_o,
    input  logic                      rd_ready_i,
    input  logic                      flush_i,
    input  logic                      overflow_clr_i,
    output logic [$clog2(Depth):0]    count_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      overflow_o,
    output logic                      timeout_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    uart_rx_entry_t  mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            push, pop, overflow_set;
    uart_rx_entry_t  wr_entry;
    uart_rx_entry_t  head;

    assign full_o  = (count_q == CntFull);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign pop          = !empty_o && rd_ready_i;
    assign push         = wr_valid_i && (!full_o || pop);
    assign overflow_set = wr_valid_i && full_o && !pop && !flush_i;

    assign wr_entry.parity_err = wr_parity_err_i;
    assign wr_entry.data       = wr_data_i;

    assign head            = mem_q[rd_ptr_q];
    assign rd_data_o       = head.data;
    assign rd_parity_err_o = head.parity_err;
    assign rd_valid_o      = !empty_o;
    assign overflow_o      = overflow_q;

    // Pointer, level and sticky-overflow next state; flush overrides push/pop.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
        if (overflow_set)        overflow_d = 1'b1;
        else if (overflow_clr_i) overflow_d = 1'b0;
    end

    // Control registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array, cleared on reset; writes suppressed during flush.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

`ifdef UART_RX_BUF_TIMEOUT_EN
    uart_rx_buffer_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .empty_i   (empty_o),
        .activity_i(push || pop || flush_i),
        .timeout_o (timeout_o)
    );
`else
    assign timeout_o = 1'b0;
`endif

endmodule : uart_rx_buffer

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer (Depth 16, TimeoutCycles 512).
module tb_uart_rx_buffer;

    logic       clk_i = 1'b0;
    logic       arst_ni;
    logic [7:0] wr_data_i;
    logic       wr_parity_err_i;
    logic       wr_valid_i;
    logic [7:0] rd_data_o;
    logic       rd_parity_err_o;
    logic       rd_valid_o;
    logic       rd_ready_i;
    logic       flush_i;
    logic       overflow_clr_i;
    logic [4:0] count_o;
    logic       full_o;
    logic       empty_o;
    logic       overflow_o;
    logic       timeout_o;

    int vectors = 0;
    int errors  = 0;

    uart_rx_buffer #(
        .Depth(16),
        .TimeoutCycles(512)
    ) dut (
        .clk_i          (clk_i),
        .arst_ni        (arst_ni),
        .wr_data_i      (wr_data_i),
        .wr_parity_err_i(wr_parity_err_i),
        .wr_valid_i     (wr_valid_i),
        .rd_data_o      (rd_data_o),
        .rd_parity_err_o(rd_parity_err_o),
        .rd_valid_o     (rd_valid_o),
        .rd_ready_i     (rd_ready_i),
        .flush_i        (flush_i),
        .overflow_clr_i (overflow_clr_i),
        .count_o        (count_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .overflow_o     (overflow_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic p);
        wr_valid_i      = 1'b1;
        wr_data_i       = d;
        wr_parity_err_i = p;
        step();
        wr_valid_i      = 1'b0;
        wr_parity_err_i = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".count"}, 32'(count_o), 0);
        check({tag, ".empty"}, 32'(empty_o), 1);
        check({tag, ".full"}, 32'(full_o), 0);
        check({tag, ".valid"}, 32'(rd_valid_o), 0);
        check({tag, ".ovf"}, 32'(overflow_o), 0);
        check({tag, ".tmo"}, 32'(timeout_o), 0);
        check({tag, ".data"}, 32'(rd_data_o), 0);
        check({tag, ".perr"}, 32'(rd_parity_err_o), 0);
    endtask

    initial begin
        arst_ni         = 1'b0;
        wr_data_i       = '0;
        wr_parity_err_i = 1'b0;
        wr_valid_i      = 1'b0;
        rd_ready_i      = 1'b0;
        flush_i         = 1'b0;
        overflow_clr_i  = 1'b0;
        #12;
        check_reset_state("rst");
        arst_ni = 1'b1;
        step();

        // Single push, FWFT head visible next cycle.
        push(8'hA5, 1'b0);
        check("one.valid", 32'(rd_valid_o), 1);
        check("one.data", 32'(rd_data_o), 32'hA5);
        check("one.count", 32'(count_o), 1);
        check("one.empty", 32'(empty_o), 0);
        rd_ready_i = 1'b1;
        step();
        rd_ready_i = 1'b0;
        check("one.drained", 32'(empty_o), 1);

        // Fill to full, then overflow.
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
        check("fill.full", 32'(full_o), 1);
        check("fill.count", 32'(count_o), 16);
        check("fill.ovf0", 32'(overflow_o), 0);
        push(8'hFF, 1'b0);
        check("ovf.set", 32'(overflow_o), 1);
        check("ovf.count", 32'(count_o), 16);
        check("ovf.full", 32'(full_o), 1);
        rd_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain.data", 32'(rd_data_o), 32'(i));
            step();
        end
        rd_ready_i = 1'b0;
        check("drain.empty", 32'(empty_o), 1);
        check("drain.ovf_sticky", 32'(overflow_o), 1);
        overflow_clr_i = 1'b1;
        step();
        overflow_clr_i = 1'b0;
        check("ovf.clr", 32'(overflow_o), 0);

        // Simultaneous push and pop at full.
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0);
        rd_ready_i = 1'b1;
        push(8'h55, 1'b0);
        rd_ready_i = 1'b0;
        check("pp.count", 32'(count_o), 16);
        check("pp.ovf", 32'(overflow_o), 0);
        rd_ready_i = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check("pp.data", 32'(rd_data_o), 32'(8'h10 + i));
            step();
        end
        check("pp.last", 32'(rd_data_o), 32'h55);
        step();
        rd_ready_i = 1'b0;
        check("pp.empty", 32'(empty_o), 1);

        // Parity flag follows its byte.
        push(8'h3C, 1'b1);
        push(8'h7E, 1'b0);
        check("par.data0", 32'(rd_data_o), 32'h3C);
        check("par.perr0", 32'(rd_parity_err_o), 1);
        rd_ready_i = 1'b1;
        step();
        check("par.data1", 32'(rd_data_o), 32'h7E);
        check("par.perr1", 32'(rd_parity_err_o), 0);
        step();
        rd_ready_i = 1'b0;
        check("par.empty", 32'(empty_o), 1);

        // Flush with coincident push; overflow left alone.
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b0);
        push(8'hEE, 1'b0);
        rd_ready_i = 1'b1;
        for (int i = 0; i < 13; i++) step();
        rd_ready_i = 1'b0;
        check("fl.pre_count", 32'(count_o), 3);
        check("fl.pre_ovf", 32'(overflow_o), 1);
        flush_i = 1'b1;
        push(8'h99, 1'b0);
        flush_i = 1'b0;
        check("fl.count", 32'(count_o), 0);
        check("fl.empty", 32'(empty_o), 1);
        check("fl.ovf", 32'(overflow_o), 1);
        overflow_clr_i = 1'b1;
        step();
        overflow_clr_i = 1'b0;
        check("fl.clr", 32'(overflow_o), 0);
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
        overflow_clr_i = 1'b1;
        push(8'hAB, 1'b0);
        overflow_clr_i = 1'b0;
        check("setclr.ovf", 32'(overflow_o), 1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        overflow_clr_i = 1'b1;
        step();
        overflow_clr_i = 1'b0;
        check("setclr.after", 32'(overflow_o), 0);

        // Idle timeout.
        push(8'h42, 1'b0);
`ifdef UART_RX_BUF_TIMEOUT_EN
        for (int i = 0; i < 511; i++) step();
        check("tmo.before", 32'(timeout_o), 0);
        step();
        check("tmo.rise", 32'(timeout_o), 1);
        step();
        check("tmo.hold", 32'(timeout_o), 1);
`else
        for (int i = 0; i < 600; i++) step();
        check("tmo.off", 32'(timeout_o), 0);
`endif
        rd_ready_i = 1'b1;
        step();
        rd_ready_i = 1'b0;
        check("tmo.fall", 32'(timeout_o), 0);
        check("tmo.empty", 32'(empty_o), 1);

        // Asynchronous reset mid-operation.
        push(8'h11, 1'b1);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        check("mid.count", 32'(count_o), 3);
        #2;
        arst_ni = 1'b0;
        #1;
        check_reset_state("mid_rst");
        @(negedge clk_i);
        arst_ni = 1'b1;
        step();
        check("post_rst.empty", 32'(empty_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_uart_rx_buffer

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Receive-side byte FIFO directly downstream of uart_rx.
- Captures each single-cycle data_valid_o pulse together with data_o and the parity_error_o flag of that frame.
- Holds up to Depth entries.
- Presents them to the APB register layer through a first-word-fall-through valid/ready read port.
- Reports fill level, full/empty, a sticky overflow flag, and an optional idle-timeout indication.

Parameters:
- Depth, 16, number of entries; power of 2, minimum 2.
- TimeoutCycles, 512, idle clk_i cycles with data present before timeout_o asserts (only used with UART_RX_BUF_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock
- arst_ni  in  1  asynchronous active-low reset
- wr_data_i  in  8  received byte (from uart_rx data_o)
- wr_parity_err_i  in  1  parity error of that byte (from uart_rx parity_error_o)
- wr_valid_i  in  1  single-cycle push strobe (from uart_rx data_valid_o); no backpressure
- rd_data_o  out  8  head-entry byte
- rd_parity_err_o  out  1  head-entry parity flag
- rd_valid_o  out  1  head entry valid (= not empty)
- rd_ready_i  in  1  consumer accepts head
- flush_i  in  1  discard all entries
- overflow_clr_i  in  1  clear sticky overflow
- count_o  out  $clog2(Depth)+1  number of stored entries, 0..Depth
- full_o  out  1  count_o == Depth
- empty_o  out  1  count_o == 0
- overflow_o  out  1  sticky: a byte was dropped
- timeout_o  out  1  idle timeout (tied 0 when feature compiled out)

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - Reset arst_ni is asynchronous, active-low.
- Reset values:
  - Pointers and count_o = 0; empty_o = 1; full_o = 0; rd_valid_o = 0.
  - overflow_o = 0; timeout_o = 0.
  - Storage array cleared to 0, so rd_data_o = 0 and rd_parity_err_o = 0.
  - Reset mid-operation discards all contents immediately.
- Storage and pointers:
  - Each entry is 9 bits: {parity_err, data}.
  - Write and read pointers are $clog2(Depth) bits wide and wrap modulo Depth.
  - count_o is a separate registered counter.
- Pop:
  - pop = rd_valid_o && rd_ready_i.
  - rd_data_o and rd_parity_err_o are driven combinationally from mem[rd_ptr] (first-word fall-through).
  - rd_ready_i while empty is ignored.
- Push:
  - push = wr_valid_i && (!full_o || pop).
  - The written byte is visible on rd_data_o one cycle after the push when the FIFO was empty; there is no same-cycle bypass.
- Simultaneous push and pop: both pointers advance and count_o is unchanged, including when full.
- Overflow:
  - Condition: wr_valid_i && full_o && !pop. The byte is dropped and overflow_o is set the next cycle.
  - overflow_o stays set until overflow_clr_i.
  - If set and clear occur in the same cycle, set wins.
- Flush:
  - flush_i zeroes the pointers and count_o next cycle.
  - Flush has priority over push and pop in the same cycle; a coincident wr_valid_i byte is discarded and does not set overflow.
  - overflow_o is not affected by flush.
- Flags: full_o and empty_o are combinational decodes of the registered count_o.

Optional Feature:
Macro UART_RX_BUF_TIMEOUT_EN.
- When defined:
  - An idle counter of width $clog2(TimeoutCycles) counts while !empty_o and no push, pop, or flush occurs.
  - The counter is cleared on any push, pop, or flush, and whenever empty.
  - When the counter equals TimeoutCycles-1 and the FIFO is still idle, timeout_o is set the next cycle.
  - timeout_o remains set until the next push, pop, or flush, or reset; the counter saturates.
- When undefined: timeout_o is a constant 0 and no counter logic is present.

Decomposition:
- Package uart_rx_buffer_pkg:
  - typedef uart_rx_entry_t as a packed struct {logic parity_err; logic [7:0] data}.
  - Constant RxDataWidth = 8.
- One sub-module, uart_rx_buffer_timer, holds the idle counter and timeout flag. It is instantiated only under UART_RX_BUF_TIMEOUT_EN.

Test Plan:
- Reset, then push 0xA5 (parity_err 0) with rd_ready_i = 0 -> next cycle rd_valid_o = 1, rd_data_o = 0xA5, count_o = 1, empty_o = 0.
- Push 16 bytes 0x00..0x0F, then a 17th byte 0xFF with rd_ready_i = 0 -> full_o = 1, overflow_o = 1, count_o = 16; draining returns 0x00..0x0F in order and never 0xFF.
- At full, push 0x55 in the same cycle as a pop -> no overflow, count_o stays 16, 0x55 is read last after draining.
- Push 0x3C with wr_parity_err_i = 1 -> rd_parity_err_o = 1 while 0x3C is at the head, 0 for the following clean byte.
- With 3 entries stored, assert flush_i together with wr_valid_i -> count_o = 0, empty_o = 1, overflow_o unchanged; overflow_clr_i then clears it; set and clear in the same cycle leave it set.
- With the macro defined and TimeoutCycles = 512, push 1 byte and stay idle -> timeout_o rises after 512 idle cycles and falls on the cycle after the pop. Assert arst_ni mid-sequence -> all outputs return to reset values.
